// File: rtl/fp8_accumulator.sv
// FP8 (1-4-3, bias 7) running accumulator fed by the multiplier's done pulse.
// Fixed six-state add pipeline; NaN/Inf/zero cases are resolved only when packing.
module fp8_accumulator #(
    parameter int BIAS       = 7,
    parameter int EXP_MAX    = 14,
    parameter int GUARD_BITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start_acc,
    input  logic       i_clear_acc,
    input  logic [7:0] i_product,
    output logic       o_busy,
    output logic       o_done_acc,
    output logic [7:0] o_acc_out
);

    localparam int SIG_W = 4 + GUARD_BITS;
    localparam int LZ_W  = $clog2(SIG_W + 1);
    localparam logic [3:0] SHIFT_LIM = 4'(SIG_W);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_PACK, S_DONE
    } state_t;

    state_t r_state, w_state_next;

    logic [7:0]           r_acc, r_a, r_b;
    logic [3:0]           r_big_exp, r_diff;
    logic [SIG_W-1:0]     r_big_sig, r_sml_sig, r_nsig;
    logic                 r_big_sign, r_sml_sign, r_sign, r_nzero;
    logic [SIG_W:0]       r_sum;
    logic signed [6:0]    r_nexp;

    logic                 w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_big;
    logic [6:0]           w_a_key, w_b_key;
    logic [SIG_W-1:0]     w_a_sig, w_b_sig, w_nsig;
    logic [LZ_W-1:0]      w_lzc;
    logic                 w_lz_found;
    logic signed [6:0]    w_nexp;
    logic [7:0]           w_norm, w_pack;
    logic                 w_unused;

    // Operand classification; zero covers flushed subnormals too.
    assign w_a_zero = (r_a[6:3] == 4'd0);
    assign w_b_zero = (r_b[6:3] == 4'd0);
    assign w_a_inf  = (r_a[6:3] == 4'hF) && (r_a[2:0] == 3'd0);
    assign w_b_inf  = (r_b[6:3] == 4'hF) && (r_b[2:0] == 3'd0);
    assign w_a_nan  = (r_a[6:3] == 4'hF) && (r_a[2:0] != 3'd0);
    assign w_b_nan  = (r_b[6:3] == 4'hF) && (r_b[2:0] != 3'd0);
    assign w_a_key  = w_a_zero ? 7'd0 : r_a[6:0];
    assign w_b_key  = w_b_zero ? 7'd0 : r_b[6:0];
    assign w_a_big  = (w_a_key >= w_b_key);
    assign w_a_sig  = w_a_zero ? '0 : {1'b1, r_a[2:0], {GUARD_BITS{1'b0}}};
    assign w_b_sig  = w_b_zero ? '0 : {1'b1, r_b[2:0], {GUARD_BITS{1'b0}}};

    always_comb begin
        w_lzc      = LZ_W'(SIG_W);
        w_lz_found = 1'b0;
        for (int i = SIG_W - 1; i >= 0; i--) begin
            if (!w_lz_found && r_sum[i]) begin
                w_lzc      = LZ_W'(SIG_W - 1 - i);
                w_lz_found = 1'b1;
            end
        end
    end

    // Exponent is carried unbiased through normalisation so underflow is a signed compare.
    always_comb begin
        if (r_sum[SIG_W]) begin
            w_nsig = r_sum[SIG_W:1];
            w_nexp = 7'(int'(r_big_exp) - BIAS + 1);
        end else begin
            w_nsig = r_sum[SIG_W-1:0] << w_lzc;
            w_nexp = 7'(int'(r_big_exp) - BIAS - int'(w_lzc));
        end
    end

    always_comb begin
        int e;
        e = int'(r_nexp);
        if (r_nzero)
            w_norm = 8'h00;
        else if (e <= -BIAS)
            w_norm = {r_sign, 7'd0};
        else if (e > EXP_MAX - BIAS)
            w_norm = {r_sign, 4'hF, 3'd0};
        else
            w_norm = {r_sign, 4'(e + BIAS), r_nsig[SIG_W-2 -: 3]};
    end

    always_comb begin
        if (w_a_nan || w_b_nan)
            w_pack = 8'h7F;
        else if (w_a_inf && w_b_inf)
            w_pack = (r_a[7] != r_b[7]) ? 8'h7F : r_a;
        else if (w_a_inf)
            w_pack = r_a;
        else if (w_b_inf)
            w_pack = r_b;
        else if (w_a_zero && w_b_zero)
            w_pack = {r_a[7] & r_b[7], 7'd0};
        else if (w_a_zero)
            w_pack = r_b;
        else if (w_b_zero)
            w_pack = r_a;
        else
            w_pack = w_norm;
    end

    assign w_unused = ^{r_nsig[SIG_W-1], r_nsig[GUARD_BITS-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:   w_state_next = i_start_acc ? S_UNPACK : S_IDLE;
            S_UNPACK: w_state_next = S_ALIGN;
            S_ALIGN:  w_state_next = S_ADD;
            S_ADD:    w_state_next = S_NORM;
            S_NORM:   w_state_next = S_PACK;
            S_PACK:   w_state_next = S_DONE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (r_state != S_IDLE);
        o_done_acc = (r_state == S_DONE);
    end

    assign o_acc_out = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0; r_a <= '0; r_b <= '0;
            r_big_exp <= '0; r_diff <= '0; r_big_sig <= '0; r_sml_sig <= '0;
            r_big_sign <= 1'b0; r_sml_sign <= 1'b0; r_sign <= 1'b0;
            r_sum <= '0; r_nsig <= '0; r_nexp <= '0; r_nzero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start_acc) begin
                        r_a <= i_clear_acc ? 8'h00 : r_acc;
                        r_b <= i_product;
                    end else if (i_clear_acc) begin
                        r_acc <= 8'h00;
                    end
                end
                S_UNPACK: begin
                    r_big_exp  <= w_a_big ? r_a[6:3] : r_b[6:3];
                    r_diff     <= w_a_big ? (r_a[6:3] - r_b[6:3]) : (r_b[6:3] - r_a[6:3]);
                    r_big_sig  <= w_a_big ? w_a_sig : w_b_sig;
                    r_sml_sig  <= w_a_big ? w_b_sig : w_a_sig;
                    r_big_sign <= w_a_big ? r_a[7] : r_b[7];
                    r_sml_sign <= w_a_big ? r_b[7] : r_a[7];
                end
                S_ALIGN:
                    r_sml_sig <= (r_diff >= SHIFT_LIM) ? '0 : (r_sml_sig >> r_diff);
                S_ADD: begin
                    r_sum  <= (r_big_sign == r_sml_sign) ? ({1'b0, r_big_sig} + {1'b0, r_sml_sig})
                                                         : ({1'b0, r_big_sig} - {1'b0, r_sml_sig});
                    r_sign <= r_big_sign;
                end
                S_NORM: begin
                    r_nsig  <= w_nsig;
                    r_nexp  <= w_nexp;
                    r_nzero <= (r_sum == '0);
                end
                S_PACK:
                    r_acc <= w_pack;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp8_accumulator.sv
// Bench for fp8_accumulator: integer-arithmetic FP8 reference, per-cycle compare,
// directed scenarios with literal results, then randomized traffic.
module tb_fp8_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] prod = 8'h00;
    logic       busy, done;
    logic [7:0] acc;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;
    bit rand_phase = 0;

    int         m_cnt  = 0;
    logic [7:0] m_acc  = 8'h00;
    logic [7:0] m_pend = 8'h00;

    always #5 clk = ~clk;

    fp8_accumulator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start_acc (start),
        .i_clear_acc (clear),
        .i_product   (prod),
        .o_busy      (busy),
        .o_done_acc  (done),
        .o_acc_out   (acc)
    );

    function automatic logic [7:0] fp_add(input logic [7:0] a, input logic [7:0] b);
        int ea, eb, vh, vl, d, e, v;
        logic [7:0] hi, lo;
        ea = int'(a[6:3]);
        eb = int'(b[6:3]);
        if ((ea == 15 && a[2:0] != 0) || (eb == 15 && b[2:0] != 0)) return 8'h7F;
        if (ea == 15 && eb == 15) return (a[7] != b[7]) ? 8'h7F : a;
        if (ea == 15) return a;
        if (eb == 15) return b;
        if (ea == 0 && eb == 0) return {a[7] & b[7], 7'd0};
        if (ea == 0) return b;
        if (eb == 0) return a;
        if (a[6:0] >= b[6:0]) begin hi = a; lo = b; end
        else begin hi = b; lo = a; end
        vh = (8 + int'(hi[2:0])) * 8;
        vl = (8 + int'(lo[2:0])) * 8;
        d  = int'(hi[6:3]) - int'(lo[6:3]);
        vl = (d >= 7) ? 0 : (vl >> d);
        v  = (hi[7] == lo[7]) ? vh + vl : vh - vl;
        e  = int'(hi[6:3]);
        if (v == 0) return 8'h00;
        if (v >= 128) begin v = v / 2; e = e + 1; end
        while (v < 64) begin v = v * 2; e = e - 1; end
        if (e <= 0) return {hi[7], 7'd0};
        if (e > 14) return {hi[7], 7'h78};
        return {hi[7], 4'(e), 3'((v / 8) % 8)};
    endfunction

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %02h want %02h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0b want %0b at %0t", name, got, want, $time);
        end
    endtask

    // Transaction-level model: a request accepted in idle completes six cycles later.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt = 0;
            m_acc = 8'h00;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_pend = fp_add(clear ? 8'h00 : m_acc, prod);
                m_cnt  = 1;
            end else if (clear) begin
                m_acc = 8'h00;
            end
        end else if (m_cnt == 6) begin
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 6) m_acc = m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check1("busy", busy, m_cnt != 0);
            check1("done", done, m_cnt == 6);
            check8("acc_out", acc, m_acc);
            if (rand_phase && done) $display("[TB] rand txn -> acc=%02h", acc);
        end
    end

    task automatic op(input logic clr, input logic [7:0] p, input logic [7:0] want,
                      input int inj_s, input int inj_c, input int rst_at);
        int c;
        bit got, aborted;
        @(negedge clk);
        start = 1'b1; clear = clr; prod = p;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        c = 1; got = 0; aborted = 0;
        while (c <= 10 && !got && !aborted) begin
            if (c == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                check1("rst_busy", busy, 1'b0);
                check1("rst_done", done, 1'b0);
                check8("rst_acc", acc, 8'h00);
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
                $display("[TB] op clr=%0b prod=%02h aborted by reset in cycle %0d", clr, p, c);
            end else if (done) begin
                got = 1;
            end else begin
                start = (c == inj_s);
                clear = (c == inj_c);
                @(negedge clk);
                c++;
            end
        end
        start = 1'b0; clear = 1'b0;
        if (!aborted) begin
            n_tests++;
            if (!got) begin
                n_fail++;
                $display("FAIL latency: no done_acc within 10 cycles, want 6");
            end else if (c != 6) begin
                n_fail++;
                $display("FAIL latency: got %0d cycles want 6", c);
            end
            check8("result", acc, want);
            $display("[TB] op clr=%0b prod=%02h -> acc=%02h after %0d cycles", clr, p, acc, c);
        end
    endtask

    initial begin
        logic [7:0] p;
        // Pin the reference model to hand-computed sums.
        check8("model_38_38", fp_add(8'h38, 8'h38), 8'h40);
        check8("model_40_30", fp_add(8'h40, 8'h30), 8'h42);
        check8("model_42_08", fp_add(8'h42, 8'h08), 8'h42);
        check8("model_3C_BC", fp_add(8'h3C, 8'hBC), 8'h00);
        check8("model_3C_3A", fp_add(8'h3C, 8'h3A), 8'h43);
        check8("model_77_77", fp_add(8'h77, 8'h77), 8'h78);
        check8("model_78_F8", fp_add(8'h78, 8'hF8), 8'h7F);
        check8("model_80_80", fp_add(8'h80, 8'h80), 8'h80);
        check8("model_00_80", fp_add(8'h00, 8'h80), 8'h00);

        repeat (2) @(negedge clk);
        check8("reset_acc", acc, 8'h00);
        check1("reset_busy", busy, 1'b0);
        check1("reset_done", done, 1'b0);
        rst_n = 1'b1;
        chk_en = 1;

        op(1'b1, 8'h38, 8'h38, 0, 0, 0);
        op(1'b0, 8'h38, 8'h40, 0, 0, 0);
        op(1'b0, 8'h30, 8'h42, 0, 0, 0);
        op(1'b0, 8'h08, 8'h42, 0, 0, 0);

        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0;
        check8("clear_alone", acc, 8'h00);
        $display("[TB] clear -> acc=%02h", acc);

        op(1'b1, 8'h3C, 8'h3C, 0, 0, 0);
        op(1'b0, 8'hBC, 8'h00, 0, 0, 0);
        op(1'b1, 8'h3C, 8'h3C, 0, 0, 0);
        op(1'b0, 8'h3A, 8'h43, 0, 0, 0);

        op(1'b1, 8'h77, 8'h77, 0, 0, 0);
        op(1'b0, 8'h77, 8'h78, 0, 0, 0);
        op(1'b0, 8'hF8, 8'h7F, 0, 0, 0);
        op(1'b0, 8'h38, 8'h7F, 0, 0, 0);

        op(1'b1, 8'h3C, 8'h3C, 0, 0, 0);
        op(1'b0, 8'h38, 8'h42, 2, 4, 0);
        repeat (3) @(negedge clk);

        op(1'b0, 8'h38, 8'h00, 0, 0, 3);
        repeat (8) @(negedge clk);
        op(1'b0, 8'h38, 8'h38, 0, 0, 0);

        rand_phase = 1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            p = 8'($urandom);
            if (p[6:3] == 4'hF && ($urandom % 8) != 0) p[6:3] = 4'($urandom_range(1, 14));
            prod  = p;
            start = (($urandom % 4) == 0);
            clear = (($urandom % 12) == 0);
        end
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        repeat (10) @(negedge clk);
        rand_phase = 0;
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp8_accumulator.md
Name: fp8_accumulator

Overview:
- Downstream stage of the FP8 multiplier in the MAC datapath.
- Consumes each 8-bit FP8 product (1 sign, 4 exponent bits with bias 7, 3 mantissa bits) when the multiplier's done pulse arrives. Adds it to a running FP8 accumulator through a fixed-latency add/align/normalise FSM.
- Exposes the accumulated sum plus a done pulse to the MAC controller.

Parameters:
- BIAS, 7, exponent bias. Matches the multiplier.
- EXP_MAX, 14, largest finite biased exponent. Exponent 15 encodes Inf/NaN.
- GUARD_BITS, 3, extra low-order bits carried through align/add before truncation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_acc  input  1  one-cycle request to add product; driven from the multiplier's done pulse.
- clear_acc  input  1  one-cycle request to zero the accumulator.
- product  input  8  FP8 addend, sampled on the start_acc edge.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done_acc  output  1  one-cycle pulse; acc_out is valid and updated.
- acc_out  output  8  current accumulator value.

Behaviour:
- Reset (async, rst_n low): state IDLE; accumulator, acc_out, done_acc and busy all 0. Reset mid-operation aborts it; no done_acc is generated.
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> PACK -> DONE -> IDLE. Every transition is unconditional except IDLE, which moves on start_acc.
- Latency: start_acc sampled at edge k gives done_acc=1 during cycle k+6. The accumulator register and acc_out update at the PACK->DONE edge.
- Special cases use the same path length; they override the result only in PACK. Latency is always 6.
- start_acc or clear_acc while busy: ignored. No queueing.
- clear_acc alone in IDLE: accumulator becomes 0x00 next edge. No done_acc.
- clear_acc and start_acc in the same IDLE cycle: the accumulator operand is taken as +0, so the result is product, normalised.
- UNPACK: latch product and the accumulator. Exponent 0 means zero (subnormals flushed). Exponent 15 with mantissa 0 is ±Inf; exponent 15 with mantissa nonzero is NaN.
- ALIGN: significand = {1, mantissa, GUARD_BITS zeros}. Shift the smaller-exponent operand right by the exponent difference; a difference of 7 or more makes it 0. Result exponent = larger exponent.
- ADD: same signs → add magnitudes. Different signs → larger magnitude minus smaller; sign taken from the larger. Exact cancellation gives +0.
- NORM:
  - Carry out: shift right 1, exponent +1.
  - Otherwise: shift left by leading-zero count, exponent minus count, done in one cycle via a priority encoder.
  - Exponent ≤ 0: result is zero with the result sign.
  - Exponent > EXP_MAX: result is ±Inf (sign,1111,000).
- PACK: mantissa = the 3 bits below the hidden 1. Guard bits are truncated (round toward zero).
- Special-case precedence:
  - Any NaN → 0x7F.
  - +Inf plus -Inf → 0x7F.
  - Inf plus finite → that Inf.
  - Zero plus x → x.
  - +0 plus -0 → +0; -0 plus -0 → -0.
- done_acc is high only in DONE. busy is low in IDLE only.

Test Plan:
- clear_acc and start_acc together with product 0x38, then start 0x38: second done_acc exactly 6 cycles after its start, acc_out 0x40. busy high for cycles 1–6.
- acc=0x40, start 0x30 → 0x42; then start 0x08 (exponent difference 7) → acc stays 0x42.
- acc=0x3C, start 0xBC → 0x00 (+0). start 0x3A with acc=0x3C → 0x43 (truncated 2.75).
- acc=0x77, start 0x77 → 0x78 (overflow to +Inf); then start 0xF8 → 0x7F (NaN); then start 0x38 → stays 0x7F.
- start_acc pulsed again during ALIGN and clear_acc during NORM: both ignored; one done_acc, result unaffected.
- Reset asserted during ADD: acc_out 0x00 and busy 0 immediately; no done_acc; next start 0x38 → 0x38.
